// File: rtl/gpio_pkg.sv
// GPIO shared types: register selects, offsets, status bit positions.
// Also carries the default pin count and the byte-enable mask helper.
`ifndef GPIO_PINS
`define GPIO_PINS 32
`endif

package gpio_pkg;

  typedef enum logic [3:0] {
    GPIO_NONE = 4'd0,
    GPIO_CR   = 4'd1,
    GPIO_ODR  = 4'd2,
    GPIO_IDR  = 4'd3,
    GPIO_SR   = 4'd4,
    GPIO_IER  = 4'd5,
    GPIO_RIER = 4'd6,
    GPIO_FIER = 4'd7,
    GPIO_ISR  = 4'd8
  } gpio_reg_t;

  localparam logic [7:0] GPIO_CR_OFF   = 8'h00;
  localparam logic [7:0] GPIO_ODR_OFF  = 8'h04;
  localparam logic [7:0] GPIO_IDR_OFF  = 8'h08;
  localparam logic [7:0] GPIO_SR_OFF   = 8'h0C;
  localparam logic [7:0] GPIO_IER_OFF  = 8'h10;
  localparam logic [7:0] GPIO_RIER_OFF = 8'h14;
  localparam logic [7:0] GPIO_FIER_OFF = 8'h18;
  localparam logic [7:0] GPIO_ISR_OFF  = 8'h1C;

  localparam int GPIO_SR_IRQ_BIT  = 0;
  localparam int GPIO_SR_PEND_BIT = 1;

  localparam int GPIO_DEFAULT_PINS = `GPIO_PINS;

  function automatic logic [31:0] be_mask(
    input logic [3:0] be
  );
    be_mask = {{8{be[3]}}, {8{be[2]}},
               {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gpio_input_sync.sv
// Pin input synchroniser chain plus previous-sample flop.
// Produces synchronised level and single-cycle edge pulses.
module gpio_input_sync #(
  parameter int PINS        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PINS-1:0] gpio_in,
  output logic [PINS-1:0] sync,
  output logic [PINS-1:0] rise,
  output logic [PINS-1:0] fall
);

  logic [SYNC_STAGES-1:0][PINS-1:0] chain;
  logic [PINS-1:0]                  prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], gpio_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/gpio_reg_file.sv
// GPIO register bank: control/output/irq registers, W1C status,
// registered read mux and level interrupt output.
module gpio_reg_file
  import gpio_pkg::*;
#(
  parameter int PINS        = GPIO_DEFAULT_PINS,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  gpio_reg_t       requested_reg,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [PINS-1:0] gpio_in,
  output logic [PINS-1:0] gpio_out,
  output logic [PINS-1:0] gpio_oe,
  output logic            irq
);

  logic [PINS-1:0] cr_q, odr_q, ier_q;
  logic [PINS-1:0] rier_q, fier_q, isr_q;
  logic [PINS-1:0] sync, rise, fall;
  logic [PINS-1:0] wm, wd, clr;
  logic [31:0]     wmask, sr_val, rd_val;
  logic sel_cr, sel_odr, sel_idr, sel_sr;
  logic sel_ier, sel_rier, sel_fier, sel_isr;
  logic any_sel;

  gpio_input_sync #(
    .PINS        (PINS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .gpio_in (gpio_in),
    .sync    (sync),
    .rise    (rise),
    .fall    (fall)
  );

  // Undefined select codes match nothing and behave as no access.
  assign sel_cr   = requested_reg == GPIO_CR;
  assign sel_odr  = requested_reg == GPIO_ODR;
  assign sel_idr  = requested_reg == GPIO_IDR;
  assign sel_sr   = requested_reg == GPIO_SR;
  assign sel_ier  = requested_reg == GPIO_IER;
  assign sel_rier = requested_reg == GPIO_RIER;
  assign sel_fier = requested_reg == GPIO_FIER;
  assign sel_isr  = requested_reg == GPIO_ISR;
  assign any_sel  = sel_cr | sel_odr | sel_idr | sel_sr
                  | sel_ier | sel_rier | sel_fier | sel_isr;

  assign wmask = be_mask(be);
  assign wm    = wmask[PINS-1:0];
  assign wd    = wdata[PINS-1:0];
  assign clr   = (we && sel_isr) ? (wd & wm) : '0;

  function automatic logic [PINS-1:0] merge(
    input logic [PINS-1:0] old
  );
    merge = (old & ~wm) | (wd & wm);
  endfunction

  assign irq      = |(isr_q & ier_q);
  assign gpio_out = odr_q;
  assign gpio_oe  = cr_q;

  always_comb begin
    sr_val = '0;
    sr_val[GPIO_SR_IRQ_BIT]  = irq;
    sr_val[GPIO_SR_PEND_BIT] = |isr_q;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_cr:   rd_val = 32'(cr_q);
      sel_odr:  rd_val = 32'(odr_q);
      sel_idr:  rd_val = 32'(sync);
      sel_sr:   rd_val = sr_val;
      sel_ier:  rd_val = 32'(ier_q);
      sel_rier: rd_val = 32'(rier_q);
      sel_fier: rd_val = 32'(fier_q);
      sel_isr:  rd_val = 32'(isr_q);
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q   <= '0;
      odr_q  <= '0;
      ier_q  <= '0;
      rier_q <= '0;
      fier_q <= '0;
      rdata  <= '0;
    end else begin
      if (we && sel_cr)   cr_q   <= merge(cr_q);
      if (we && sel_odr)  odr_q  <= merge(odr_q);
      if (we && sel_ier)  ier_q  <= merge(ier_q);
      if (we && sel_rier) rier_q <= merge(rier_q);
      if (we && sel_fier) fier_q <= merge(fier_q);
      if (!we && any_sel) rdata  <= rd_val;
    end
  end

  // New edges are OR-ed in after the clear, so a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isr_q <= '0;
    end else begin
      isr_q <= (isr_q & ~clr)
             | (rise & rier_q)
             | (fall & fier_q);
    end
  end

endmodule

// File: tb/tb_gpio_reg_file.sv
// Scoreboard bench for gpio_reg_file: reads queue expected data,
// a monitor checks rdata one cycle later; pin/irq checks inline.
module tb_gpio_reg_file;
  import gpio_pkg::*;

  localparam int PINS = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  gpio_reg_t       requested_reg = GPIO_NONE;
  logic            we = 1'b0;
  logic [3:0]      be = 4'h0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic [PINS-1:0] gpio_in = '0;
  logic [PINS-1:0] gpio_out;
  logic [PINS-1:0] gpio_oe;
  logic            irq;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic rvalid;

  gpio_reg_file #(
    .PINS        (PINS),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .requested_reg (requested_reg),
    .we            (we),
    .be            (be),
    .wdata         (wdata),
    .rdata         (rdata),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .gpio_oe       (gpio_oe),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Decoder model: rvalid one cycle after a read access.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid <= 1'b0;
    else rvalid <= (requested_reg != GPIO_NONE) && !we;
  end

  always @(negedge clk) begin
    if (rvalid) begin
      exp_t e;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read: rdata %h with empty queue",
                 rdata);
      end else begin
        e = q.pop_front();
        if (rdata !== e.exp) begin
          miscompares++;
          $display("FAIL %s: rdata %h expected %h",
                   e.name, rdata, e.exp);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    requested_reg = GPIO_NONE;
    we = 1'b0;
  endtask

  task automatic wr(input gpio_reg_t r, input logic [3:0] b,
                    input logic [31:0] d);
    @(negedge clk);
    requested_reg = r;
    we = 1'b1;
    be = b;
    wdata = d;
  endtask

  task automatic rd(input gpio_reg_t r, input logic [31:0] e,
                    input string n);
    exp_t x;
    @(negedge clk);
    requested_reg = r;
    we = 1'b0;
    x.name = n;
    x.exp = e;
    q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gpio_oe", gpio_oe, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    // byte-enabled write
    wr(GPIO_ODR, 4'b0101, 32'hA5A5_1234);
    idle();
    chk("be_gpio_out", gpio_out, 32'h00A5_0034);
    rd(GPIO_ODR, 32'h00A5_0034, "be_odr_read");
    wr(GPIO_CR, 4'b0011, 32'h1234_FFFF);
    idle();
    chk("cr_gpio_oe", gpio_oe, 32'h0000_FFFF);
    rd(GPIO_CR, 32'h0000_FFFF, "cr_read");

    // rising edge interrupt, 3-cycle latency
    wr(GPIO_RIER, 4'hF, 32'h1);
    wr(GPIO_IER, 4'hF, 32'h1);
    idle();
    gpio_in[0] = 1'b1;
    idle();
    idle();
    chk("rise_irq_early", 32'(irq), 32'h0);
    idle();
    chk("rise_irq", 32'(irq), 32'h1);
    rd(GPIO_ISR, 32'h1, "rise_isr");
    wr(GPIO_ISR, 4'hF, 32'h1);
    idle();
    chk("w1c_irq", 32'(irq), 32'h0);
    gpio_in[0] = 1'b0;
    repeat (4) idle();
    rd(GPIO_ISR, 32'h0, "fall_no_fier");
    idle();
    chk("fall_irq", 32'(irq), 32'h0);

    // W1C collides with a new rise: set wins
    gpio_in[0] = 1'b1;
    idle();
    wr(GPIO_ISR, 4'hF, 32'h1);
    idle();
    chk("collide_irq", 32'(irq), 32'h1);
    rd(GPIO_ISR, 32'h1, "collide_isr");
    wr(GPIO_ISR, 4'hF, 32'h1);
    idle();
    chk("clear_irq", 32'(irq), 32'h0);
    rd(GPIO_ISR, 32'h0, "clear_isr");

    // masking
    wr(GPIO_RIER, 4'hF, 32'h5);
    wr(GPIO_IER, 4'hF, 32'h4);
    idle();
    gpio_in = 32'h5;
    repeat (4) idle();
    chk("mask_irq_on", 32'(irq), 32'h1);
    wr(GPIO_IER, 4'hF, 32'h0);
    idle();
    chk("mask_irq_off", 32'(irq), 32'h0);
    rd(GPIO_SR, 32'h2, "mask_sr");
    rd(GPIO_ISR, 32'h4, "mask_isr");

    // read-only registers and undefined select
    gpio_in = 32'h0000_00F0;
    repeat (4) idle();
    wr(GPIO_IDR, 4'hF, 32'hFFFF_FFFF);
    wr(GPIO_SR, 4'hF, 32'hFFFF_FFFF);
    wr(gpio_reg_t'(4'hF), 4'hF, 32'hFFFF_FFFF);
    rd(GPIO_IDR, 32'h0000_00F0, "idr_read");
    rd(GPIO_SR, 32'h2, "sr_ro");
    rd(GPIO_ODR, 32'h00A5_0034, "bad_sel_odr");
    idle();
    wr(GPIO_ODR, 4'hF, 32'hFFFF_FFFF);
    idle();
    chk("rdata_hold", rdata, 32'h00A5_0034);
    rd(GPIO_ODR, 32'hFFFF_FFFF, "odr_full");
    wr(GPIO_IER, 4'hF, 32'h4);
    idle();
    chk("pre_rst_irq", 32'(irq), 32'h1);
    idle();

    // asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gpio_out", gpio_out, 32'h0);
    chk("arst_gpio_oe", gpio_oe, 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(GPIO_ISR, 32'h0, "arst_isr");
    rd(GPIO_ODR, 32'h0, "arst_odr");
    rd(GPIO_IER, 32'h0, "arst_ier");
    idle();
    idle();
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
